// File: rtl/rsa_pkg.sv
// ============================================================================
// Package     : rsa_pkg
// Description : Shared defaults and enums for the RSA exponentiation datapath.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rsa_pkg;

    localparam int WIDTH_DEFAULT     = 1024;
    localparam int EXP_WIDTH_DEFAULT = 32;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PRE  = 3'd1,
        SQR  = 3'd2,
        MUL  = 3'd3,
        NEXT = 3'd4,
        POST = 3'd5,
        DONE = 3'd6
    } mont_exp_state_t;

    typedef enum logic [1:0] {
        SEL_MSG_R2N = 2'd0,
        SEL_AA      = 2'd1,
        SEL_AX      = 2'd2,
        SEL_A1      = 2'd3
    } mm_sel_t;

endpackage

`default_nettype wire

// File: rtl/mont_exp_scan.sv
// ============================================================================
// Module      : mont_exp_scan
// Description : Exponent shift register and remaining-bit counter, MSB first.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mont_exp_scan
    import rsa_pkg::*;
#(
    parameter int EXP_WIDTH = EXP_WIDTH_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic                 shift,
    input  logic [EXP_WIDTH-1:0] exp,
    input  logic [5:0]           exp_len,
    output logic                 cur_bit,
    output logic                 last,
    output logic                 empty
);

    localparam int CW = $clog2(EXP_WIDTH + 1);

    logic [EXP_WIDTH-1:0] r_sh;
    logic [CW-1:0]        r_cnt;
    logic [CW-1:0]        w_len;
    logic [CW-1:0]        w_pad;

    // Left-align the scanned bits so the current bit is always the MSB.
    always_comb begin
        w_len = (int'(exp_len) > EXP_WIDTH) ? CW'(EXP_WIDTH) : CW'(exp_len);
        w_pad = CW'(EXP_WIDTH) - w_len;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sh  <= '0;
            r_cnt <= '0;
        end else if (load) begin
            r_sh  <= exp << w_pad;
            r_cnt <= w_len;
        end else if (shift && (r_cnt != '0)) begin
            r_sh  <= {r_sh[EXP_WIDTH-2:0], 1'b0};
            r_cnt <= r_cnt - CW'(1);
        end
    end

    assign cur_bit = r_sh[EXP_WIDTH-1];
    assign last    = (r_cnt <= CW'(1));
    assign empty   = (r_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/mont_exp.sv
// ============================================================================
// Module      : mont_exp
// Description : Left-to-right square-and-multiply sequencer driving a
//               Montgomery multiplier core. Optional busy-cycle counter
//               output enabled by MONT_EXP_CYCLE_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mont_exp
    import rsa_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEFAULT,
    parameter int EXP_WIDTH = EXP_WIDTH_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     msg,
    input  logic [WIDTH-1:0]     n,
    input  logic [WIDTH-1:0]     r2n,
    input  logic [WIDTH-1:0]     rn,
    input  logic [EXP_WIDTH-1:0] exp,
    input  logic [5:0]           exp_len,
    output logic                 mm_start,
    output logic [WIDTH-1:0]     mm_a,
    output logic [WIDTH-1:0]     mm_b,
    output logic [WIDTH-1:0]     mm_m,
    input  logic [WIDTH-1:0]     mm_result,
    input  logic                 mm_done,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH-1:0]     result
`ifdef MONT_EXP_CYCLE_CNT_EN
    ,
    output logic [31:0]          cycles
`endif
);

    mont_exp_state_t r_state;
    mont_exp_state_t w_next;
    mm_sel_t         w_sel;

    logic [WIDTH-1:0] r_msg;
    logic [WIDTH-1:0] r_n;
    logic [WIDTH-1:0] r_r2n;
    logic [WIDTH-1:0] r_x;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_result;
    logic             r_issued;
    logic             r_got;

    logic w_op;
    logic w_accept;
    logic w_fire;
    logic w_capture;
    logic w_cur_bit;
    logic w_last;
    logic w_empty;

    mont_exp_scan #(
        .EXP_WIDTH (EXP_WIDTH)
    ) u_scan (
        .clk     (clk),
        .reset   (reset),
        .load    (w_accept),
        .shift   (r_state == NEXT),
        .exp     (exp),
        .exp_len (exp_len),
        .cur_bit (w_cur_bit),
        .last    (w_last),
        .empty   (w_empty)
    );

    // r_issued: core started in this state; r_got: its result is captured.
    always_comb begin
        w_op      = r_state inside {PRE, SQR, MUL, POST};
        w_accept  = (r_state == IDLE) && start;
        w_fire    = w_op && !r_issued;
        w_capture = w_op && r_issued && !r_got && mm_done;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = PRE;
            PRE:     if (r_got) w_next = w_empty ? POST : SQR;
            SQR:     if (r_got) w_next = w_cur_bit ? MUL : NEXT;
            MUL:     if (r_got) w_next = NEXT;
            NEXT:    w_next = w_last ? POST : SQR;
            POST:    if (r_got) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        case (r_state)
            PRE:     w_sel = SEL_MSG_R2N;
            SQR:     w_sel = SEL_AA;
            MUL:     w_sel = SEL_AX;
            default: w_sel = SEL_A1;
        endcase
        mm_a = '0;
        mm_b = '0;
        if (w_op) begin
            case (w_sel)
                SEL_MSG_R2N: begin mm_a = r_msg; mm_b = r_r2n; end
                SEL_AA:      begin mm_a = r_a;   mm_b = r_a;   end
                SEL_AX:      begin mm_a = r_a;   mm_b = r_x;   end
                default:     begin mm_a = r_a;   mm_b = {{(WIDTH-1){1'b0}}, 1'b1}; end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_msg    <= '0;
            r_n      <= '0;
            r_r2n    <= '0;
            r_x      <= '0;
            r_a      <= '0;
            r_result <= '0;
            r_issued <= 1'b0;
            r_got    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_msg <= msg;
                r_n   <= n;
                r_r2n <= r2n;
                r_a   <= rn;
            end
            if (w_fire) begin
                r_issued <= 1'b1;
            end
            if (w_capture) begin
                r_got <= 1'b1;
                if (r_state == PRE) begin
                    r_x <= mm_result;
                end else begin
                    r_a <= mm_result;
                end
            end
            if (r_got) begin
                r_issued <= 1'b0;
                r_got    <= 1'b0;
            end
            // Publish on entry to DONE so result is valid alongside the done pulse.
            if ((r_state == POST) && r_got) begin
                r_result <= r_a;
            end
        end
    end

    assign mm_start = w_fire;
    assign mm_m     = r_n;
    assign busy     = (r_state != IDLE);
    assign done     = (r_state == DONE);
    assign result   = r_result;

`ifdef MONT_EXP_CYCLE_CNT_EN
    logic [31:0] r_cycles;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cycles <= '0;
        end else if (w_accept) begin
            r_cycles <= '0;
        end else if (r_state != IDLE) begin
            r_cycles <= r_cycles + 32'd1;
        end
    end

    assign cycles = r_cycles;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mont_exp.sv
// ============================================================================
// Module      : tb_mont_exp
// Description : Directed bench for mont_exp with a behavioural Montgomery core.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mont_exp;

    localparam int W   = 1024;
    localparam int EW  = 32;
    localparam int LAT = 10;
    localparam logic [63:0] N64 = 64'd1000003;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [W-1:0]  msg, n, r2n, rn;
    logic [EW-1:0] exp;
    logic [5:0]    exp_len;
    logic          mm_start;
    logic [W-1:0]  mm_a, mm_b, mm_m, mm_result;
    logic          mm_done;
    logic          busy, done;
    logic [W-1:0]  result;
`ifdef MONT_EXP_CYCLE_CNT_EN
    logic [31:0]   cycles;
`endif

    mont_exp dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .msg       (msg),
        .n         (n),
        .r2n       (r2n),
        .rn        (rn),
        .exp       (exp),
        .exp_len   (exp_len),
        .mm_start  (mm_start),
        .mm_a      (mm_a),
        .mm_b      (mm_b),
        .mm_m      (mm_m),
        .mm_result (mm_result),
        .mm_done   (mm_done),
        .busy      (busy),
        .done      (done),
        .result    (result)
`ifdef MONT_EXP_CYCLE_CNT_EN
        ,
        .cycles    (cycles)
`endif
    );

    always #5 clk = ~clk;

    // Radix-2 Montgomery product a*b*2^-W mod m.
    function automatic logic [W-1:0] mont_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic [W-1:0] m);
        logic [W+1:0] s;
        s = '0;
        for (int i = 0; i < W; i++) begin
            if (a[i]) s = s + {2'b00, b};
            if (s[0]) s = s + {2'b00, m};
            s = s >> 1;
        end
        if (s >= {2'b00, m}) s = s - {2'b00, m};
        return s[W-1:0];
    endfunction

    function automatic logic [63:0] ref_pow(input logic [63:0] m, input logic [EW-1:0] e,
                                            input int len);
        logic [63:0] a;
        a = 64'd1;
        for (int i = len - 1; i >= 0; i--) begin
            a = (a * a) % N64;
            if (e[i]) a = (a * m) % N64;
        end
        return a;
    endfunction

    function automatic logic [63:0] r_mod_n();
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < W; i++) r = (r * 64'd2) % N64;
        return r;
    endfunction

    logic         core_done = 1'b0;
    logic         spur_done = 1'b0;
    logic         core_busy = 1'b0;
    logic [W-1:0] core_res  = '0;
    logic [W-1:0] core_out  = '0;
    int           core_cnt  = 0;

    assign mm_done   = core_done | spur_done;
    assign mm_result = core_out;

    always @(posedge clk) begin
        if (reset) begin
            core_busy <= 1'b0;
            core_cnt  <= 0;
            core_done <= 1'b0;
            core_out  <= '0;
        end else begin
            core_done <= 1'b0;
            if (mm_start) begin
                core_res  <= mont_mul(mm_a, mm_b, mm_m);
                core_cnt  <= LAT;
                core_busy <= 1'b1;
            end else if (core_busy) begin
                if (core_cnt == 1) begin
                    core_done <= 1'b1;
                    core_out  <= core_res;
                    core_busy <= 1'b0;
                end else begin
                    core_cnt <= core_cnt - 1;
                end
            end
        end
    end

    int n_starts = 0;
    int n_dones  = 0;
    int n_busy   = 0;

    always @(posedge clk) begin
        if (mm_start) n_starts <= n_starts + 1;
        if (done)     n_dones  <= n_dones + 1;
        if (busy)     n_busy   <= n_busy + 1;
    end

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        checks++;
        assert (obs === expv) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs[63:0], expv[63:0]);
        end
    endtask

    task automatic wait_done(input string tag, output logic [W-1:0] res);
        bit got;
        got = 1'b0;
        res = '0;
        for (int c = 0; c < 5000; c++) begin
            if (done) begin
                got = 1'b1;
                res = result;
                break;
            end
            @(negedge clk);
        end
        check(tag, W'(got), W'(1'b1));
    endtask

    task automatic run(input logic [W-1:0] m, input logic [EW-1:0] e, input logic [5:0] len,
                       input string tag, output logic [W-1:0] res, output int starts,
                       output int dones);
        int s0, d0;
        s0 = n_starts;
        d0 = n_dones;
        @(negedge clk);
        msg = m; exp = e; exp_len = len; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(tag, res);
        @(negedge clk);
        starts = n_starts - s0;
        dones  = n_dones - d0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [63:0] rn_v, r2n_v;
    logic [W-1:0] res;
    int starts, dones, s0, d0, b0;

    initial begin
        reset = 1'b1; start = 1'b0; msg = '0; n = '0; r2n = '0; rn = '0;
        exp = '0; exp_len = '0;
        rn_v  = r_mod_n();
        r2n_v = (rn_v * rn_v) % N64;
        repeat (3) @(negedge clk);
        check("rst_busy",     W'(busy),     W'(1'b0));
        check("rst_done",     W'(done),     W'(1'b0));
        check("rst_mm_start", W'(mm_start), W'(1'b0));
        check("rst_result",   result,       '0);
        check("rst_mm_a",     mm_a,         '0);
        check("rst_mm_m",     mm_m,         '0);

        reset = 1'b0;
        n = W'(N64); r2n = W'(r2n_v); rn = W'(rn_v);

        // Stray core completion while idle.
        @(negedge clk); spur_done = 1'b1;
        @(negedge clk); spur_done = 1'b0;
        check("spur_busy", W'(busy), W'(1'b0));
        check("spur_done", W'(done), W'(1'b0));

        // Case 1: 2^0b1011 = 2048
        b0 = n_busy;
        run(W'(2), 32'hB, 6'd4, "t1_timeout", res, starts, dones);
        check("t1_result", res,        W'(2048));
        check("t1_starts", W'(starts), W'(9));
        check("t1_dones",  W'(dones),  W'(1));
`ifdef MONT_EXP_CYCLE_CNT_EN
        check("t1_cycles", W'(cycles), W'(n_busy - b0));
`endif

        // Case 2: zero-length exponent
        run(W'(12345), 32'hABCD, 6'd0, "t2_timeout", res, starts, dones);
        check("t2_result", res,        W'(1));
        check("t2_starts", W'(starts), W'(2));

        // Case 3: exp_len clamped to 32
        run(W'(123457), 32'hFFFF_FFFF, 6'd40, "t3_timeout", res, starts, dones);
        check("t3_result", res,        W'(ref_pow(64'd123457, 32'hFFFF_FFFF, 32)));
        check("t3_starts", W'(starts), W'(66));

        // Case 4: restart request and input changes while busy; 3^5 = 243
        s0 = n_starts; d0 = n_dones;
        @(negedge clk);
        msg = W'(3); exp = 32'd5; exp_len = 6'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0; msg = W'(7); exp = 32'hF; exp_len = 6'd9;
        repeat (20) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("t4_timeout", res);
        repeat (3) @(negedge clk);
        check("t4_result", res,                W'(243));
        check("t4_starts", W'(n_starts - s0), W'(7));
        check("t4_dones",  W'(n_dones - d0),  W'(1));
        check("t4_idle",   W'(busy),           W'(1'b0));

        // Case 5: reset during the first MUL, then a clean rerun; 5^3 = 125
        s0 = n_starts; d0 = n_dones;
        @(negedge clk);
        msg = W'(5); exp = 32'd3; exp_len = 6'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 2000 && (n_starts - s0) < 3; c++) @(negedge clk);
        check("t5_reach_mul", W'(n_starts - s0), W'(3));
        reset = 1'b1;
        @(negedge clk);
        check("t5_rst_busy",     W'(busy),     W'(1'b0));
        check("t5_rst_mm_start", W'(mm_start), W'(1'b0));
        check("t5_rst_done",     W'(done),     W'(1'b0));
        reset = 1'b0;
        n = W'(N64); r2n = W'(r2n_v); rn = W'(rn_v);
        run(W'(5), 32'd3, 6'd2, "t5_timeout", res, starts, dones);
        check("t5_result", res,                W'(125));
        check("t5_starts", W'(starts),         W'(6));
        check("t5_dones",  W'(n_dones - d0),   W'(1));

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

`default_nettype wire
